adc_scan_avg: RTL

- Parametrised scan sequencer and averager that drives the modular ADC core's Avalon-ST command interface and consumes its response stream.
- Walks NUM_CH consecutive ADC channels starting at FIRST_CH.
- Takes 2^AVG_LOG2 samples per channel and emits one averaged result per channel on a backpressured result stream.
- Supports single-shot and continuous scan, response-channel checking and a response timeout with automatic command retry.

---
 rtl/adc_scan_avg.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/adc_scan_avg.sv
// Scan sequencer and per-channel averager for the modular ADC core.
// It issues Avalon-ST commands, averages 2^AVG_LOG2 responses per channel, and emits results.
module adc_scan_avg #(
  parameter int NUM_CH      = 4,
  parameter int FIRST_CH    = 1,
  parameter int CH_W        = 5,
  parameter int DATA_W      = 12,
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              start,
  input  logic              cont_mode,
  input  logic              stop,
  output logic              command_valid,
  output logic [CH_W-1:0]   command_channel,
  output logic              command_startofpacket,
  output logic              command_endofpacket,
  input  logic              command_ready,
  input  logic              response_valid,
  input  logic [CH_W-1:0]   response_channel,
  input  logic [DATA_W-1:0] response_data,
  output logic              result_valid,
  output logic [CH_W-1:0]   result_channel,
  output logic [DATA_W-1:0] result_data,
  input  logic              result_ready,
  output logic              busy,
  output logic              done,
  output logic              ch_err,
  output logic              tmo_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] EMIT = 2'd3;

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int TMO_W = $clog2(TIMEOUT_CYC);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [TMO_W-1:0] tmo_cnt;
  logic             cont_lat;
  logic             stop_lat;

  logic [CH_W-1:0]  exp_ch;
  logic             resp_match;
  logic             tmo_hit;

  assign exp_ch     = CH_W'(FIRST_CH) + CH_W'(idx);
  assign resp_match = response_valid && (response_channel == exp_ch);
  assign tmo_hit    = (tmo_cnt == TMO_LAST);

  assign busy                  = (state != IDLE);
  assign command_valid         = (state == CMD);
  assign command_channel       = command_valid ? exp_ch : '0;
  assign command_startofpacket = command_valid;
  assign command_endofpacket   = command_valid;

  // The accumulator is constant in EMIT, so the shifted average needs no extra register.
  assign result_valid   = (state == EMIT);
  assign result_channel = result_valid ? exp_ch : '0;
  assign result_data    = result_valid ? acc[ACC_W-1:AVG_LOG2] : '0;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      acc      <= '0;
      tmo_cnt  <= '0;
      cont_lat <= 1'b0;
      stop_lat <= 1'b0;
      done     <= 1'b0;
      ch_err   <= 1'b0;
      tmo_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy && stop) stop_lat <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            cont_lat <= cont_mode;
            idx      <= '0;
            cnt      <= '0;
            acc      <= '0;
            ch_err   <= 1'b0;
            tmo_err  <= 1'b0;
            stop_lat <= 1'b0;
            state    <= CMD;
          end
        end

        CMD: begin
          if (command_ready) begin
            tmo_cnt <= '0;
            state   <= WAIT;
          end
        end

        // A matching response takes priority over a timeout in the same cycle.
        WAIT: begin
          if (resp_match) begin
            acc   <= acc + ACC_W'(response_data);
            cnt   <= cnt + CNT_W'(1);
            state <= (cnt == LAST_CNT) ? EMIT : CMD;
          end else begin
            if (response_valid) ch_err <= 1'b1;
            if (tmo_hit) begin
              tmo_err <= 1'b1;
              state   <= CMD;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
        end

        EMIT: begin
          if (result_ready) begin
            acc <= '0;
            cnt <= '0;
            if (stop_lat || stop) begin
              idx      <= '0;
              stop_lat <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else if (idx != LAST_IDX) begin
              idx   <= idx + IDX_W'(1);
              state <= CMD;
            end else begin
              idx <= '0;
              if (cont_lat) begin
                state <= CMD;
              end else begin
                stop_lat <= 1'b0;
                done     <= 1'b1;
                state    <= IDLE;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
